// File: rtl/memory_writer.sv
`default_nettype none
// ============================================================================
// Module   : memory_writer
// Brief    : Writes one frame of raster-order result pixels into block RAM.
// Revision : 1.0 - initial release
// ============================================================================
module memory_writer #(
    parameter int IMG_W = 98,
    parameter int IMG_H = 98,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          pix_valid_i,
    input  logic [7:0]    pix_data_i,
    output logic          pix_ready_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_din_o,
    output logic [6:0]    row_o,
    output logic [6:0]    col_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_ovf_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [6:0]    c_last_col = 7'(IMG_W - 1);
    localparam logic [6:0]    c_last_row = 7'(IMG_H - 1);
    localparam logic [6:0]    c_one7     = 7'd1;
    localparam logic [AW-1:0] c_addr_one = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [6:0]    row_q, row_d;
    logic [6:0]    col_q, col_d;
    logic [AW-1:0] addr_cnt_q, addr_cnt_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_din_q, mem_din_d;
    logic          err_q, err_d;

    logic w_last_col;
    logic w_last_beat;

    assign w_last_col  = (col_q == c_last_col);
    assign w_last_beat = w_last_col && (row_q == c_last_row);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            addr_cnt_q <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            addr_cnt_q <= addr_cnt_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        addr_cnt_d = addr_cnt_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_WRITE;
                    row_d      = '0;
                    col_d      = '0;
                    addr_cnt_d = '0;
                    // A pixel arriving with start is still an overflow.
                    err_d      = pix_valid_i;
                end else if (pix_valid_i) begin
                    err_d = 1'b1;
                end
            end
            S_WRITE: begin
                if (pix_valid_i) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = addr_cnt_q;
                    mem_din_d  = pix_data_i;
                    addr_cnt_d = addr_cnt_q + c_addr_one;
                    if (w_last_beat) begin
                        // Position freezes on the final pixel until next start.
                        state_d = S_DRAIN;
                    end else if (w_last_col) begin
                        col_d = '0;
                        row_d = row_q + c_one7;
                    end else begin
                        col_d = col_q + c_one7;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                if (pix_valid_i) err_d = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (pix_valid_i) err_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pix_ready_o = (state_q == S_WRITE);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_din_o   = mem_din_q;
    assign row_o       = row_q;
    assign col_o       = col_q;
    assign err_ovf_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_writer
// Brief    : Directed self-checking bench for memory_writer (4x3 and 98x98).
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_writer;

    logic clk;
    logic rst;

    // Small 4x3 instance
    logic        s_start, s_valid;
    logic [7:0]  s_data;
    logic        s_ready, s_we, s_busy, s_done, s_err;
    logic [3:0]  s_addr;
    logic [7:0]  s_din;
    logic [6:0]  s_row, s_col;

    // Default-size instance
    logic        b_start, b_valid;
    logic [7:0]  b_data;
    logic        b_ready, b_we, b_busy, b_done, b_err;
    logic [13:0] b_addr;
    logic [7:0]  b_din;
    logic [6:0]  b_row, b_col;

    int n_checks = 0;
    int n_fail   = 0;

    int b_wr_cnt    = 0;
    int b_done_cnt  = 0;
    int b_order_err = 0;
    int b_expect    = 0;
    int b_last_addr = -1;

    memory_writer #(.IMG_W(4), .IMG_H(3), .AW(4)) u_small (
        .clk(clk), .rst(rst), .start_i(s_start), .pix_valid_i(s_valid),
        .pix_data_i(s_data), .pix_ready_o(s_ready), .mem_we_o(s_we),
        .mem_addr_o(s_addr), .mem_din_o(s_din), .row_o(s_row), .col_o(s_col),
        .busy_o(s_busy), .done_o(s_done), .err_ovf_o(s_err)
    );

    memory_writer u_big (
        .clk(clk), .rst(rst), .start_i(b_start), .pix_valid_i(b_valid),
        .pix_data_i(b_data), .pix_ready_o(b_ready), .mem_we_o(b_we),
        .mem_addr_o(b_addr), .mem_din_o(b_din), .row_o(b_row), .col_o(b_col),
        .busy_o(b_busy), .done_o(b_done), .err_ovf_o(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (b_we) begin
            b_wr_cnt++;
            b_last_addr = int'(b_addr);
            if (int'(b_addr) != b_expect) b_order_err++;
            b_expect++;
        end
        if (b_done) b_done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"}, s_ready, 0);
        check({tag, "_we"},    s_we,    0);
        check({tag, "_addr"},  s_addr,  0);
        check({tag, "_din"},   s_din,   0);
        check({tag, "_row"},   s_row,   0);
        check({tag, "_col"},   s_col,   0);
        check({tag, "_busy"},  s_busy,  0);
        check({tag, "_done"},  s_done,  0);
        check({tag, "_err"},   s_err,   0);
    endtask

    // One 4x3 frame; start_at pulses a stray start alongside that beat.
    task automatic run_frame(input bit do_start, input bit gaps, input int start_at);
        if (do_start) begin
            s_start = 1'b1;
            tick();
            s_start = 1'b0;
            check("start_busy", s_busy, 1);
            check("start_we",   s_we,   0);
            check("start_err",  s_err,  0);
        end
        for (int i = 0; i < 12; i++) begin
            check("pre_row",   s_row,   i / 4);
            check("pre_col",   s_col,   i % 4);
            check("pre_ready", s_ready, 1);
            s_valid = 1'b1;
            s_data  = 8'h10 + 8'(i);
            s_start = (i == start_at);
            tick();
            s_valid = 1'b0;
            s_start = 1'b0;
            check("wr_we",   s_we,   1);
            check("wr_addr", s_addr, i);
            check("wr_din",  s_din,  32'h10 + i);
            if (i == 11) begin
                check("drain_ready", s_ready, 0);
                check("drain_done",  s_done,  0);
                check("final_row",   s_row,   2);
                check("final_col",   s_col,   3);
            end else if (gaps) begin
                tick();
                check("gap_we",   s_we,   0);
                check("gap_addr", s_addr, i);
                check("gap_din",  s_din,  32'h10 + i);
            end
        end
        tick();
        check("done_pulse", s_done, 1);
        check("done_we",    s_we,   0);
        check("done_busy",  s_busy, 1);
        tick();
        check("after_done",   s_done, 0);
        check("after_busy",   s_busy, 0);
        check("hold_row",     s_row,  2);
        check("hold_col",     s_col,  3);
    endtask

    initial begin
        rst = 1'b1;
        s_start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        b_start = 1'b0; b_valid = 1'b0; b_data = 8'h00;
        #1;
        check_zero_outputs("reset");
        tick(); tick();
        rst = 1'b0;
        tick();
        check_zero_outputs("idle");

        // Back-to-back, then with gaps, then a stray start after beat 3
        run_frame(1'b1, 1'b0, -1);
        run_frame(1'b1, 1'b1, -1);
        run_frame(1'b1, 1'b0, 3);

        // Pixel offered while idle is dropped and flagged
        s_valid = 1'b1; s_data = 8'hAA;
        tick();
        s_valid = 1'b0;
        check("ovf_we",  s_we,  0);
        check("ovf_err", s_err, 1);
        tick();
        check("ovf_sticky", s_err, 1);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("ovf_clear", s_err, 0);
        run_frame(1'b0, 1'b0, -1);

        // Start and pixel in the same idle cycle
        s_start = 1'b1; s_valid = 1'b1; s_data = 8'hEE;
        tick();
        s_start = 1'b0; s_valid = 1'b0;
        check("both_err",  s_err,  1);
        check("both_we",   s_we,   0);
        check("both_busy", s_busy, 1);
        run_frame(1'b0, 1'b0, -1);

        // Asynchronous reset mid-frame after beat 5
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 8'h40 + 8'(i);
            tick();
        end
        s_valid = 1'b0;
        check("mid_we", s_we, 1);
        #2 rst = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abandon_we",   s_we,   0);
            check("abandon_done", s_done, 0);
        end
        run_frame(1'b1, 1'b0, -1);

        // Full default-size frame
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 98 * 98; i++) begin
            b_valid = 1'b1;
            b_data  = 8'(i);
            tick();
        end
        b_valid = 1'b0;
        check("big_drain_ready", b_ready, 0);
        check("big_row", b_row, 97);
        check("big_col", b_col, 97);
        tick(); tick(); tick();
        check("big_wr_cnt",    b_wr_cnt,    9604);
        check("big_last_addr", b_last_addr, 9603);
        check("big_order",     b_order_err, 0);
        check("big_done_cnt",  b_done_cnt,  1);
        check("big_busy",      b_busy,      0);
        check("big_err",       b_err,       0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
